// File: rtl/video_pkg.sv
// Shared definitions for the video fade stage.
//   fade_state_e  : brightness fade state machine encoding
//   GAIN_UNITY    : gain value that passes luma unchanged (256/256)
//   COORD_W       : width of the active-area x/y coordinates
//   coord_sat_inc : saturating +1 for coordinate counters
package video_pkg;

  localparam int COORD_W = 10;
  localparam logic [8:0] GAIN_UNITY = 9'd256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_e;

  // Coordinates stick at their maximum instead of wrapping.
  function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
    logic [COORD_W-1:0] res;
    if (v == {COORD_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + COORD_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/fade_gain_ctrl.sv
// Frame-synchronous brightness fade controller.
// Ports:
//   clk, reset   : pixel clock, synchronous active-high reset
//   frame_tick   : one-clock pulse at the start of vertical blanking
//   fade_start   : single-cycle request to fade in
//   fade_abort   : single-cycle request to fade out immediately
//   gain         : registered gain 0..256 (256 = unity)
//   busy         : registered, high whenever the state is not IDLE
// Commands are latched every clock and acted on at the next frame_tick, so
// the gain only ever changes between frames. A command arriving in the same
// clock as the tick is honoured by that tick.
module fade_gain_ctrl
  import video_pkg::*;
#(
  parameter int FADE_STEP   = 8,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fade_start,
  input  logic       fade_abort,
  output logic [8:0] gain,
  output logic       busy
);

  localparam logic [9:0]  STEP10   = 10'(FADE_STEP);
  localparam logic [8:0]  STEP9    = 9'(FADE_STEP);
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_FRAMES);

  fade_state_e state_r, state_next_s;
  logic [8:0]  gain_r, gain_next_s;
  logic [15:0] hold_cnt_r, hold_cnt_next_s, hold_inc_s;
  logic [9:0]  gain_up_s;
  logic        pend_start_r, pend_abort_r;
  logic        pend_start_next_s, pend_abort_next_s;
  logic        start_s, abort_s;
  logic        busy_r;

  assign start_s = pend_start_r | fade_start;
  assign abort_s = pend_abort_r | fade_abort;

  // Next-state, gain and hold-counter update; everything holds between ticks.
  always_comb begin
    state_next_s      = state_r;
    gain_next_s       = gain_r;
    hold_cnt_next_s   = hold_cnt_r;
    pend_start_next_s = start_s;
    pend_abort_next_s = abort_s;
    gain_up_s         = {1'b0, gain_r} + STEP10;
    hold_inc_s        = hold_cnt_r + 16'd1;
    if (frame_tick) begin
      pend_start_next_s = 1'b0;
      pend_abort_next_s = 1'b0;
      case (state_r)
        IDLE: begin
          gain_next_s = 9'd0;
          if (start_s && !abort_s) begin
            state_next_s = FADE_IN;
          end else begin
            state_next_s = IDLE;
          end
        end
        FADE_IN: begin
          if (abort_s) begin
            // Turn around without a gain step on this tick.
            state_next_s = FADE_OUT;
          end else if (gain_up_s >= {1'b0, GAIN_UNITY}) begin
            gain_next_s     = GAIN_UNITY;
            state_next_s    = HOLD;
            hold_cnt_next_s = 16'd0;
          end else begin
            gain_next_s = gain_up_s[8:0];
          end
        end
        HOLD: begin
          if (abort_s) begin
            state_next_s = FADE_OUT;
          end else if (start_s) begin
            hold_cnt_next_s = 16'd0;
          end else begin
            // >= so that HOLD_FRAMES = 0 leaves on the first tick in HOLD.
            hold_cnt_next_s = hold_inc_s;
            if (hold_inc_s >= HOLD_LIM) begin
              state_next_s = FADE_OUT;
            end else begin
              state_next_s = HOLD;
            end
          end
        end
        FADE_OUT: begin
          if (start_s && !abort_s) begin
            // Resume fading in from wherever the gain currently is.
            state_next_s = FADE_IN;
          end else if ({1'b0, gain_r} <= STEP10) begin
            gain_next_s  = 9'd0;
            state_next_s = IDLE;
          end else begin
            gain_next_s = gain_r - STEP9;
          end
        end
        default: begin
          state_next_s    = IDLE;
          gain_next_s     = 9'd0;
          hold_cnt_next_s = 16'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      gain_r       <= 9'd0;
      hold_cnt_r   <= 16'd0;
      pend_start_r <= 1'b0;
      pend_abort_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      gain_r       <= gain_next_s;
      hold_cnt_r   <= hold_cnt_next_s;
      pend_start_r <= pend_start_next_s;
      pend_abort_r <= pend_abort_next_s;
      busy_r       <= (state_next_s != IDLE);
    end
  end

  assign gain = gain_r;
  assign busy = busy_r;

endmodule

// File: rtl/video_fade_stage.sv
// Video fade stage: scales upstream luma by a frame-synchronous fade gain and
// expands it to tinted RGB, keeping timing aligned (2 ce_pix of latency).
// Ports:
//   clk, reset                       : pixel clock, synchronous active-high reset
//   ce_pix                           : pixel enable, all video state advances on it
//   hblank/hsync/vblank/vsync_in     : upstream timing
//   video_in[7:0]                    : upstream luma
//   fade_start, fade_abort           : single-cycle fade commands
//   hblank/hsync/vblank/vsync_out    : timing delayed by 2 ce_pix
//   r_out, g_out, b_out [7:0]        : faded, tinted pixel (TINT = {R,G,B} enables)
//   gain[8:0], busy                  : fade controller status
//   x_pos, y_pos [9:0]               : active coordinates of the stage-1 pixel
// Build option: define BORDER_EN to draw a full-white border (first/last pixel
// of each line and first active line) independent of the fade gain.
module video_fade_stage
  import video_pkg::*;
#(
  parameter int         FADE_STEP   = 8,
  parameter int         HOLD_FRAMES = 120,
  parameter logic [2:0] TINT        = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic               hblank_in,
  input  logic               hsync_in,
  input  logic               vblank_in,
  input  logic               vsync_in,
  input  logic [7:0]         video_in,
  input  logic               fade_start,
  input  logic               fade_abort,
  output logic               hblank_out,
  output logic               hsync_out,
  output logic               vblank_out,
  output logic               vsync_out,
  output logic [7:0]         r_out,
  output logic [7:0]         g_out,
  output logic [7:0]         b_out,
  output logic [8:0]         gain,
  output logic               busy,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos
);

  logic               hblank_s1_r, hsync_s1_r, vblank_s1_r, vsync_s1_r;
  logic [7:0]         video_s1_r;
  logic               active_s1_r;
  logic [COORD_W-1:0] x_pos_r, y_pos_r, x_next_s, y_next_s;
  logic               hblank_s2_r, hsync_s2_r, vblank_s2_r, vsync_s2_r;
  logic [7:0]         r_s2_r, g_s2_r, b_s2_r;
  logic [16:0]        product_s;
  logic [7:0]         pix_val_s;
  logic               unused_product_s;
  logic               frame_tick_s;
  logic [8:0]         gain_s;
  logic               busy_s;

  // vblank_s1_r holds vblank_in from the previous ce_pix, so this is its rising edge.
  assign frame_tick_s = ce_pix & vblank_in & ~vblank_s1_r;

  fade_gain_ctrl #(
    .FADE_STEP  (FADE_STEP),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_gain_ctrl (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick_s),
    .fade_start(fade_start),
    .fade_abort(fade_abort),
    .gain      (gain_s),
    .busy      (busy_s)
  );

`ifdef BORDER_EN
  logic last_pix_s;
  logic border_s;
  // The stage-1 pixel is the last of its line when the next one is already blanked.
  assign last_pix_s = active_s1_r & hblank_in;
  assign border_s   = (x_pos_r == {COORD_W{1'b0}}) | (y_pos_r == {COORD_W{1'b0}}) | last_pix_s;
`endif

  // Next coordinates for the pixel being captured into stage 1.
  always_comb begin
    x_next_s = x_pos_r;
    y_next_s = y_pos_r;
    if (hblank_in) begin
      x_next_s = {COORD_W{1'b0}};
    end else if (active_s1_r) begin
      x_next_s = coord_sat_inc(x_pos_r);
    end else begin
      x_next_s = {COORD_W{1'b0}};
    end
    if (vblank_in) begin
      y_next_s = {COORD_W{1'b0}};
    end else if (hblank_in && !hblank_s1_r) begin
      y_next_s = coord_sat_inc(y_pos_r);
    end else begin
      y_next_s = y_pos_r;
    end
  end

  // Scale stage-1 luma by the gain; blanking forces black.
  always_comb begin
    pix_val_s = 8'd0;
    product_s = {9'd0, video_s1_r} * {8'd0, gain_s};
    if (hblank_s1_r || vblank_s1_r) begin
      pix_val_s = 8'd0;
`ifdef BORDER_EN
    end else if (border_s) begin
      pix_val_s = 8'hFF;
`endif
    end else begin
      pix_val_s = product_s[15:8];
    end
  end

  // Only product[15:8] is meaningful: unity gain is a left shift by 8.
  assign unused_product_s = ^{product_s[16], product_s[7:0]};

  // Stage 1: capture timing, luma and coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_s1_r <= 1'b0;
      hsync_s1_r  <= 1'b0;
      vblank_s1_r <= 1'b0;
      vsync_s1_r  <= 1'b0;
      video_s1_r  <= 8'd0;
      active_s1_r <= 1'b0;
      x_pos_r     <= {COORD_W{1'b0}};
      y_pos_r     <= {COORD_W{1'b0}};
    end else if (ce_pix) begin
      hblank_s1_r <= hblank_in;
      hsync_s1_r  <= hsync_in;
      vblank_s1_r <= vblank_in;
      vsync_s1_r  <= vsync_in;
      video_s1_r  <= video_in;
      active_s1_r <= ~hblank_in;
      x_pos_r     <= x_next_s;
      y_pos_r     <= y_next_s;
    end else begin
      active_s1_r <= active_s1_r;
    end
  end

  // Stage 2: delayed timing and tinted output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_s2_r <= 1'b0;
      hsync_s2_r  <= 1'b0;
      vblank_s2_r <= 1'b0;
      vsync_s2_r  <= 1'b0;
      r_s2_r      <= 8'd0;
      g_s2_r      <= 8'd0;
      b_s2_r      <= 8'd0;
    end else if (ce_pix) begin
      hblank_s2_r <= hblank_s1_r;
      hsync_s2_r  <= hsync_s1_r;
      vblank_s2_r <= vblank_s1_r;
      vsync_s2_r  <= vsync_s1_r;
      r_s2_r      <= TINT[2] ? pix_val_s : 8'd0;
      g_s2_r      <= TINT[1] ? pix_val_s : 8'd0;
      b_s2_r      <= TINT[0] ? pix_val_s : 8'd0;
    end else begin
      hblank_s2_r <= hblank_s2_r;
    end
  end

  assign hblank_out = hblank_s2_r;
  assign hsync_out  = hsync_s2_r;
  assign vblank_out = vblank_s2_r;
  assign vsync_out  = vsync_s2_r;
  assign r_out      = r_s2_r;
  assign g_out      = g_s2_r;
  assign b_out      = b_s2_r;
  assign gain       = gain_s;
  assign busy       = busy_s;
  assign x_pos      = x_pos_r;
  assign y_pos      = y_pos_r;

endmodule

// File: tb/tb_video_fade_stage.sv
// Bench for video_fade_stage: two instances (red-only and green/blue tint)
// share one stimulus stream of tiny frames (2 active lines of 4 pixels plus
// one vertical-blank line). A frame table lists the command injected in each
// frame and the gain/busy expected right after that frame's tick; the pixel
// scoreboard derives expected RGB from the gain in force during the frame.
module tb_video_fade_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce_pix, hblank_in, hsync_in, vblank_in, vsync_in;
  logic [7:0] video_in;
  logic       fade_start, fade_abort;

  logic       hblank_out, hsync_out, vblank_out, vsync_out, busy;
  logic [7:0] r_out, g_out, b_out;
  logic [8:0] gain;
  logic [9:0] x_pos, y_pos;

  logic       hblank_out2, hsync_out2, vblank_out2, vsync_out2, busy2;
  logic [7:0] r_out2, g_out2, b_out2;
  logic [8:0] gain2;
  logic [9:0] x_pos2, y_pos2;

  video_fade_stage #(.FADE_STEP(8), .HOLD_FRAMES(3), .TINT(3'b100)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hblank_in(hblank_in), .hsync_in(hsync_in), .vblank_in(vblank_in), .vsync_in(vsync_in),
    .video_in(video_in), .fade_start(fade_start), .fade_abort(fade_abort),
    .hblank_out(hblank_out), .hsync_out(hsync_out), .vblank_out(vblank_out), .vsync_out(vsync_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .gain(gain), .busy(busy),
    .x_pos(x_pos), .y_pos(y_pos)
  );

  video_fade_stage #(.FADE_STEP(8), .HOLD_FRAMES(3), .TINT(3'b011)) dut2 (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hblank_in(hblank_in), .hsync_in(hsync_in), .vblank_in(vblank_in), .vsync_in(vsync_in),
    .video_in(video_in), .fade_start(fade_start), .fade_abort(fade_abort),
    .hblank_out(hblank_out2), .hsync_out(hsync_out2), .vblank_out(vblank_out2), .vsync_out(vsync_out2),
    .r_out(r_out2), .g_out(g_out2), .b_out(b_out2), .gain(gain2), .busy(busy2),
    .x_pos(x_pos2), .y_pos(y_pos2)
  );

  typedef struct packed {
    logic [3:0]  tim;
    logic [23:0] rgb_a;
    logic [23:0] rgb_b;
  } exp_t;

  typedef struct {
    logic [1:0] cmd;     // bit0 start, bit1 abort
    logic       vary;    // vary luma across the frame
    logic [8:0] exp_gain;
    logic       exp_busy;
  } frame_vec_t;

  frame_vec_t vecs [0:159];
  int         n_vec;
  exp_t       sb[$];
  exp_t       last_e;
  logic [8:0] cur_gain;
  int         checks, errors, px_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic cmp_outputs(input string name);
    check({name, "_tim"},  {hblank_out, hsync_out, vblank_out, vsync_out}, last_e.tim);
    check({name, "_rgb"},  {r_out, g_out, b_out}, last_e.rgb_a);
    check({name, "_tim2"}, {hblank_out2, hsync_out2, vblank_out2, vsync_out2}, last_e.tim);
    check({name, "_rgb2"}, {r_out2, g_out2, b_out2}, last_e.rgb_b);
  endtask

  task automatic add_vec(input logic [1:0] c, input logic vary, input logic [8:0] g, input logic bz);
    vecs[n_vec].cmd      = c;
    vecs[n_vec].vary     = vary;
    vecs[n_vec].exp_gain = g;
    vecs[n_vec].exp_busy = bz;
    n_vec++;
  endtask

  task automatic model_reset();
    sb.delete();
    sb.push_back('0);
    last_e   = '0;
    cur_gain = 9'd0;
  endtask

  task automatic drive_px(input logic hb, input logic hs, input logic vb, input logic vs,
                          input logic [7:0] vid, input logic st, input logic ab,
                          input logic [9:0] ex, input logic [9:0] ey);
    exp_t        e;
    logic [16:0] prod;
    logic [7:0]  val;
    @(negedge clk);
    ce_pix = 1'b1; hblank_in = hb; hsync_in = hs; vblank_in = vb; vsync_in = vs;
    video_in = vid; fade_start = st; fade_abort = ab;
    prod    = {9'd0, vid} * {8'd0, cur_gain};
    val     = (hb || vb) ? 8'd0 : prod[15:8];
    e.tim   = {hb, hs, vb, vs};
    e.rgb_a = {val, 8'd0, 8'd0};
    e.rgb_b = {8'd0, val, val};
    sb.push_back(e);
    @(posedge clk); #1;
    fade_start = 1'b0; fade_abort = 1'b0;
    if (sb.size() > 1) begin
      last_e = sb.pop_front();
      cmp_outputs("pix");
    end
    check("xy",  {x_pos, y_pos},   {ex, ey});
    check("xy2", {x_pos2, y_pos2}, {ex, ey});
    px_cnt++;
    if (px_cnt % 3 == 0) begin
      @(negedge clk); ce_pix = 1'b0;
      @(posedge clk); #1;
      cmp_outputs("hold");
      check("xy_hold", {x_pos, y_pos}, {ex, ey});
    end
  endtask

  task automatic run_frame(input logic [1:0] cmd, input logic vary);
    logic       hb, hs, vb, vs, st, ab;
    logic [7:0] vid;
    logic [9:0] ex, ey;
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < 6; i++) begin
        vb  = (ln == 2);
        hb  = (i >= 4);
        hs  = (i == 5);
        vs  = vb && (i < 3);
        vid = vary ? 8'(8'h37 + i * 29 + ln * 71) : 8'h80;
        st  = (ln == 0) && (i == 1) && cmd[0];
        ab  = (ln == 0) && (i == 1) && cmd[1];
        ex  = (i < 4) ? 10'(i) : 10'd0;
        ey  = vb ? 10'd0 : ((i < 4) ? 10'(ln) : 10'(ln + 1));
        drive_px(hb, hs, vb, vs, vid, st, ab, ex, ey);
      end
    end
  endtask

  task automatic check_frame(input logic [8:0] g, input logic bz);
    check("gain",  gain,  g);
    check("busy",  busy,  bz);
    check("gain2", gain2, g);
    check("busy2", busy2, bz);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; px_cnt = 0; n_vec = 0;

    // Idle frames.
    add_vec(2'd0, 1'b0, 9'd0, 1'b0);
    add_vec(2'd0, 1'b0, 9'd0, 1'b0);
    // Full fade-in, hold for 3 ticks, full fade-out.
    add_vec(2'd1, 1'b0, 9'd0, 1'b1);
    for (int i = 1; i <= 32; i++) add_vec(2'd0, 1'b0, 9'(8 * i), 1'b1);
    for (int i = 0; i < 3; i++)   add_vec(2'd0, 1'b0, 9'd256, 1'b1);
    for (int i = 1; i <= 32; i++) add_vec(2'd0, 1'b0, 9'(256 - 8 * i), i < 32);
    // Abort at 96, restart at 88, abort again at 104, run down to idle.
    add_vec(2'd0, 1'b1, 9'd0, 1'b0);
    add_vec(2'd1, 1'b1, 9'd0, 1'b1);
    for (int i = 1; i <= 12; i++) add_vec(2'd0, 1'b1, 9'(8 * i), 1'b1);
    add_vec(2'd2, 1'b1, 9'd96, 1'b1);
    add_vec(2'd0, 1'b1, 9'd88, 1'b1);
    add_vec(2'd1, 1'b1, 9'd88, 1'b1);
    add_vec(2'd0, 1'b1, 9'd96, 1'b1);
    add_vec(2'd0, 1'b1, 9'd104, 1'b1);
    add_vec(2'd2, 1'b1, 9'd104, 1'b1);
    for (int i = 1; i <= 13; i++) add_vec(2'd0, 1'b1, 9'(104 - 8 * i), i < 13);
    // Into HOLD; a start restarts the hold count; start+abort together leaves.
    add_vec(2'd1, 1'b1, 9'd0, 1'b1);
    for (int i = 1; i <= 32; i++) add_vec(2'd0, 1'b1, 9'(8 * i), 1'b1);
    add_vec(2'd0, 1'b1, 9'd256, 1'b1);
    add_vec(2'd1, 1'b1, 9'd256, 1'b1);
    add_vec(2'd0, 1'b1, 9'd256, 1'b1);
    add_vec(2'd0, 1'b1, 9'd256, 1'b1);
    add_vec(2'd3, 1'b1, 9'd256, 1'b1);
    add_vec(2'd0, 1'b1, 9'd248, 1'b1);
    add_vec(2'd0, 1'b1, 9'd240, 1'b1);

    // Reset with busy inputs and a start request that must not survive.
    reset = 1'b1; ce_pix = 1'b1; hblank_in = 1'b1; hsync_in = 1'b1; vblank_in = 1'b1;
    vsync_in = 1'b1; video_in = 8'hA5; fade_start = 1'b1; fade_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tim", {hblank_out, hsync_out, vblank_out, vsync_out}, 4'd0);
    check("rst_rgb", {r_out, g_out, b_out, r_out2, g_out2, b_out2}, 48'd0);
    check("rst_gain_busy", {gain, busy}, 10'd0);
    check("rst_xy", {x_pos, y_pos}, 20'd0);
    @(negedge clk);
    reset = 1'b0; ce_pix = 1'b0; fade_start = 1'b0;
    hblank_in = 1'b0; hsync_in = 1'b0; vblank_in = 1'b0; vsync_in = 1'b0;
    model_reset();

    for (int f = 0; f < n_vec; f++) begin
      run_frame(vecs[f].cmd, vecs[f].vary);
      check_frame(vecs[f].exp_gain, vecs[f].exp_busy);
      cur_gain = vecs[f].exp_gain;
    end

    // Reset in the middle of a fade-out, part-way into a line.
    drive_px(1'b0, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 10'd0, 10'd0);
    drive_px(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 10'd1, 10'd0);
    @(negedge clk);
    reset = 1'b1; ce_pix = 1'b1; hblank_in = 1'b1; vblank_in = 1'b1; hsync_in = 1'b1;
    @(posedge clk); #1;
    check("midrst_gain_busy", {gain, busy}, 10'd0);
    check("midrst_out", {hblank_out, hsync_out, vblank_out, vsync_out, r_out, g_out, b_out}, 28'd0);
    @(negedge clk);
    reset = 1'b0; ce_pix = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("postrst_hold", {hblank_out, hsync_out, vblank_out, r_out}, 11'd0);
    run_frame(2'd0, 1'b1);
    check_frame(9'd0, 1'b0);
    run_frame(2'd1, 1'b1);
    check_frame(9'd0, 1'b1);
    run_frame(2'd0, 1'b1);
    check_frame(9'd8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
